// File: rtl/butterfly_unit_3_if.sv
// Handshake and operand/result bundle for the radix-2 DIT butterfly.
// The master side is the sample sequencer plus output buffer; the slave is the butterfly.
interface butterfly_unit_3_if #(
  parameter int DW = 12
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x0_re;
  logic signed [DW-1:0] x0_im;
  logic signed [DW-1:0] x1_re;
  logic signed [DW-1:0] x1_im;
  logic signed [DW-1:0] w_re;
  logic signed [DW-1:0] w_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW:0]   y0_re;
  logic signed [DW:0]   y0_im;
  logic signed [DW:0]   y1_re;
  logic signed [DW:0]   y1_im;
  logic                 sat;

  modport master (
    output in_valid, x0_re, x0_im, x1_re, x1_im, w_re, w_im, out_ready,
    input  in_ready, out_valid, y0_re, y0_im, y1_re, y1_im, sat
  );

  modport slave (
    input  in_valid, x0_re, x0_im, x1_re, x1_im, w_re, w_im, out_ready,
    output in_ready, out_valid, y0_re, y0_im, y1_re, y1_im, sat
  );
endinterface

// File: rtl/butterfly_unit_3.sv
// Radix-2 DIT butterfly: y0 = x0 + w*x1, y1 = x0 - w*x1.
// The complex product uses four parallel radix-2 Booth shift-add multipliers,
// one multiplier bit per cycle. ADD reduces and saturates the product; the
// first HOLD cycle forms the sum/difference and raises out_valid.
module butterfly_unit_3 #(
  parameter int DW      = 12,
  parameter int TW_FRAC = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  butterfly_unit_3_if.slave    bus
);

  localparam int CW = $clog2(DW);
  localparam logic signed [2*DW:0] SAT_MAX = $signed({{(DW+2){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [2*DW:0] SAT_MIN = $signed({{(DW+2){1'b1}}, {(DW-1){1'b0}}});

  typedef enum logic [1:0] {IDLE, MUL, ADD, HOLD} state_t;

  state_t state, next_state;

  logic [CW-1:0]          cnt;
  logic signed [DW-1:0]   x0_re_q, x0_im_q;
  logic signed [2*DW-1:0] m_re, m_im;
  logic [DW-1:0]          q_re, q_im;
  logic                   prev_re, prev_im;
  logic signed [2*DW-1:0] ac, bd, ad, bc;
  logic signed [DW-1:0]   p_re, p_im;
  logic                   p_sat;
  logic                   out_valid_q;
  logic signed [DW:0]     y0_re_q, y0_im_q, y1_re_q, y1_im_q;
  logic                   sat_q;

  logic signed [2*DW:0]   re_sum, im_sum, re_shift, im_shift;
  logic signed [DW-1:0]   p_re_n, p_im_n;
  logic                   re_sat, im_sat;

  // Booth recoding of the pair {current bit, previous bit}: 01 adds, 10 subtracts.
  function automatic logic signed [2*DW-1:0] booth_term(input logic [1:0] pair,
                                                         input logic signed [2*DW-1:0] m);
    case (pair)
      2'b01:   return m;
      2'b10:   return -m;
      default: return '0;
    endcase
  endfunction

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.y0_re     = y0_re_q;
  assign bus.y0_im     = y0_im_q;
  assign bus.y1_re     = y1_re_q;
  assign bus.y1_im     = y1_im_q;
  assign bus.sat       = sat_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode: accept in IDLE, count out the multiplier bits, hold until taken.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.in_valid) next_state = MUL;
      MUL:  if (cnt == '0) next_state = ADD;
      ADD:  next_state = HOLD;
      HOLD: if (out_valid_q && bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Reduce the four partial products to p at 2*DW+1 bits, floor-shift and clamp to DW bits.
  always_comb begin
    re_sum   = {ac[2*DW-1], ac} - {bd[2*DW-1], bd};
    im_sum   = {ad[2*DW-1], ad} + {bc[2*DW-1], bc};
    re_shift = re_sum >>> TW_FRAC;
    im_shift = im_sum >>> TW_FRAC;
    p_re_n   = re_shift[DW-1:0];
    p_im_n   = im_shift[DW-1:0];
    re_sat   = 1'b0;
    im_sat   = 1'b0;
    if (re_shift > SAT_MAX) begin
      p_re_n = SAT_MAX[DW-1:0];
      re_sat = 1'b1;
    end else if (re_shift < SAT_MIN) begin
      p_re_n = SAT_MIN[DW-1:0];
      re_sat = 1'b1;
    end
    if (im_shift > SAT_MAX) begin
      p_im_n = SAT_MAX[DW-1:0];
      im_sat = 1'b1;
    end else if (im_shift < SAT_MIN) begin
      p_im_n = SAT_MIN[DW-1:0];
      im_sat = 1'b1;
    end
  end

  // Datapath: operand capture, Booth iteration, product reduction and output formation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      x0_re_q     <= '0;
      x0_im_q     <= '0;
      m_re        <= '0;
      m_im        <= '0;
      q_re        <= '0;
      q_im        <= '0;
      prev_re     <= 1'b0;
      prev_im     <= 1'b0;
      ac          <= '0;
      bd          <= '0;
      ad          <= '0;
      bc          <= '0;
      p_re        <= '0;
      p_im        <= '0;
      p_sat       <= 1'b0;
      out_valid_q <= 1'b0;
      y0_re_q     <= '0;
      y0_im_q     <= '0;
      y1_re_q     <= '0;
      y1_im_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x0_re_q <= bus.x0_re;
            x0_im_q <= bus.x0_im;
            m_re    <= {{DW{bus.x1_re[DW-1]}}, bus.x1_re};
            m_im    <= {{DW{bus.x1_im[DW-1]}}, bus.x1_im};
            q_re    <= bus.w_re;
            q_im    <= bus.w_im;
            prev_re <= 1'b0;
            prev_im <= 1'b0;
            ac      <= '0;
            bd      <= '0;
            ad      <= '0;
            bc      <= '0;
            cnt     <= CW'(DW - 1);
          end
        end
        MUL: begin
          ac      <= ac + booth_term({q_re[0], prev_re}, m_re);
          bc      <= bc + booth_term({q_re[0], prev_re}, m_im);
          bd      <= bd + booth_term({q_im[0], prev_im}, m_im);
          ad      <= ad + booth_term({q_im[0], prev_im}, m_re);
          m_re    <= m_re <<< 1;
          m_im    <= m_im <<< 1;
          prev_re <= q_re[0];
          prev_im <= q_im[0];
          q_re    <= {q_re[DW-1], q_re[DW-1:1]};
          q_im    <= {q_im[DW-1], q_im[DW-1:1]};
          cnt     <= cnt - 1'b1;
        end
        ADD: begin
          p_re  <= p_re_n;
          p_im  <= p_im_n;
          p_sat <= re_sat | im_sat;
        end
        HOLD: begin
          if (!out_valid_q) begin
            y0_re_q     <= {x0_re_q[DW-1], x0_re_q} + {p_re[DW-1], p_re};
            y0_im_q     <= {x0_im_q[DW-1], x0_im_q} + {p_im[DW-1], p_im};
            y1_re_q     <= {x0_re_q[DW-1], x0_re_q} - {p_re[DW-1], p_re};
            y1_im_q     <= {x0_im_q[DW-1], x0_im_q} - {p_im[DW-1], p_im};
            sat_q       <= p_sat;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_butterfly_unit_3.sv
// Self-checking bench for butterfly_unit_3: directed vector table plus
// backpressure and mid-multiply reset sequences.
module tb_butterfly_unit_3;

  localparam int DW = 12;

  typedef struct {
    logic signed [DW-1:0] x0r, x0i, x1r, x1i, wr, wi;
    logic signed [DW:0]   y0r, y0i, y1r, y1i;
    logic                 s;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs [7];

  butterfly_unit_3_if #(.DW(DW)) bus ();

  butterfly_unit_3 #(.DW(DW), .TW_FRAC(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic driveOperands(input vec_t v);
    bus.x0_re = v.x0r;
    bus.x0_im = v.x0i;
    bus.x1_re = v.x1r;
    bus.x1_im = v.x1i;
    bus.w_re  = v.wr;
    bus.w_im  = v.wi;
  endtask

  // Offer one operand set, then measure accept-to-out_valid latency.
  task automatic applyStimulus(input vec_t v, input string name);
    int cyc;
    cyc = 0;
    while (!bus.in_ready && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check({name, "_ready_wait"}, int'(bus.in_ready), 1);
    driveOperands(v);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({name, "_in_ready_drop"}, int'(bus.in_ready), 0);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check({name, "_latency"}, cyc, 14);
  endtask

  task automatic checkHeld(input vec_t v, input string name);
    check({name, "_y0_re"}, int'(bus.y0_re), int'(v.y0r));
    check({name, "_y0_im"}, int'(bus.y0_im), int'(v.y0i));
    check({name, "_y1_re"}, int'(bus.y1_re), int'(v.y1r));
    check({name, "_y1_im"}, int'(bus.y1_im), int'(v.y1i));
    check({name, "_sat"},   int'(bus.sat),   int'(v.s));
  endtask

  // Compare the held result, then take it and confirm return to IDLE.
  task automatic checkOutput(input vec_t v, input string name);
    checkHeld(v, name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({name, "_out_valid_drop"}, int'(bus.out_valid), 0);
    check({name, "_in_ready_back"},  int'(bus.in_ready),  1);
  endtask

  initial begin
    vec_t junk;
    int   stale;
    checks   = 0;
    failures = 0;

    //            x0r    x0i   x1r    x1i   wr     wi     y0r    y0i   y1r    y1i   s
    vecs[0] = '{  100,    0,    50,    0,  128,     0,   150,    0,    50,    0, 1'b0};
    vecs[1] = '{    0,    0,    64,   32,    0,  -128,    32,  -64,   -32,   64, 1'b0};
    vecs[2] = '{   10,   10,    -1,    0,   64,     0,     9,   10,    11,   10, 1'b0};
    vecs[3] = '{ 2047,    0,  2047, 2047,  128,  -128,  4094,    0,     0,    0, 1'b1};
    vecs[4] = '{    0,    0, -2048,    0, -2048,    0,  2047,    0, -2047,    0, 1'b1};
    vecs[5] = '{ -300,  200,  1000, -500,   90,   -90,    51, -855,  -651, 1255, 1'b0};
    vecs[6] = '{-2048,    5, -2048, 2047,  127,   127, -4096,    4,     0,    6, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    driveOperands(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready",  int'(bus.in_ready),  1);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_y0_re",     int'(bus.y0_re),     0);
    check("reset_y1_im",     int'(bus.y1_im),     0);
    check("reset_sat",       int'(bus.sat),       0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result must stay frozen while in_valid toggles operands.
    applyStimulus(vecs[5], "bp");
    for (int k = 0; k < 5; k++) begin
      junk = vecs[0];
      junk.x0r = DW'($urandom);
      junk.x1r = DW'($urandom);
      junk.wi  = DW'($urandom);
      driveOperands(junk);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_out_valid_held", int'(bus.out_valid), 1);
      check("bp_in_ready_low",   int'(bus.in_ready),  0);
      checkHeld(vecs[5], "bp_hold");
    end
    driveOperands(vecs[1]);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_out_valid_drop", int'(bus.out_valid), 0);
    check("bp_in_ready_back",  int'(bus.in_ready),  1);
    applyStimulus(vecs[1], "bp_next");
    checkOutput(vecs[1], "bp_next");

    // Reset during the fifth MUL cycle discards the in-flight butterfly.
    driveOperands(vecs[2]);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mul_out_valid", int'(bus.out_valid), 0);
    check("rst_mul_in_ready",  int'(bus.in_ready),  1);
    check("rst_mul_y0_re",     int'(bus.y0_re),     0);
    check("rst_mul_y0_im",     int'(bus.y0_im),     0);
    check("rst_mul_y1_re",     int'(bus.y1_re),     0);
    check("rst_mul_sat",       int'(bus.sat),       0);
    stale = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) stale++;
    end
    check("rst_mul_no_stale", stale, 0);
    applyStimulus(vecs[0], "post_rst");
    checkOutput(vecs[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
